deserializer_vrtl: RTL and testbench
====================================

# deserializer_vrtl

Collects `N_SAMPLES` consecutive `BIT_WIDTH`-bit words arriving one per handshake on a serial val/rdy input. It presents them together as one parallel frame on a val/rdy output. It is the parallel-reassembly stage of the SERDES link, and its output frame has the same shape as the serializer's parallel input. Words are stored in arrival order: the first word accepted lands in `send_msg[0]`.

## Interface
- `BIT_WIDTH`, 32, width of one sample word.
- `N_SAMPLES`, 8, words per frame; legal values are 2 and above.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 resets immediately, independent of `clk`.
- `recv_msg`  in  `BIT_WIDTH`  serial input word.
- `recv_val`  in  1  input word valid.
- `recv_rdy`  out  1  block can accept a word.
- `send_msg`  out  `BIT_WIDTH` x `N_SAMPLES` (unpacked array `[N_SAMPLES-1:0]`)  assembled frame.
- `send_val`  out  1  frame complete and valid.
- `send_rdy`  in  1  downstream accepts the frame.

## Operation
- Storage: `N_SAMPLES` word registers `buf[i]`. `send_msg[i] = buf[i]` combinationally, at all times.
- Write counter `cnt` is `$clog2(N_SAMPLES)` bits, ranging 0..`N_SAMPLES-1`.
- Two-state FSM with states COLLECT and FULL.
- **COLLECT**
  - `recv_rdy=1`, `send_val=0`.
  - On `recv_val`: `buf[cnt] <= recv_msg`.
  - If `cnt == N_SAMPLES-1`: `cnt <= 0` and go to FULL. Otherwise `cnt <= cnt+1`.
  - No `recv_val`: hold state and count.
- **FULL**
  - `send_val=1`.
  - `recv_rdy` is 0, unless `DESERIALIZER_OVERLAP_EN` is defined (see Configuration).
  - On `send_rdy`: go to COLLECT.
  - Without `send_rdy`: hold. `buf` is frozen and `send_msg` is stable while `send_val` is high.
- Counter wrap: `cnt` never reaches `N_SAMPLES`. It wraps to 0 exactly on the frame's last accepted word.
- Reset (`reset==0`), asynchronous:
  - State becomes COLLECT, `cnt=0`, all `buf` become 0.
  - Outputs: `send_val=0`, `send_msg` all 0, `recv_rdy=0` (forced low while reset is asserted).
- Reset mid-frame: the partial frame is discarded. The first word accepted after reset is written to `buf[0]`.
- Reset while FULL: the frame is dropped and `send_val` falls immediately.

## Timing
- A word is accepted at a rising edge where `recv_val && recv_rdy`. A frame transfers at an edge where `send_val && send_rdy`.
- Latency: if the last word of a frame is accepted at edge k, `send_val` is 1 in the cycle after edge k. That is one cycle of latency after the final word.
- The minimum frame period is `N_SAMPLES+1` cycles without overlap and `N_SAMPLES` cycles with it, assuming continuous `recv_val` and `send_rdy`.
- `send_val` and `send_msg` are functions of registered state only.
- `recv_rdy` is registered-state-only without the macro. With the macro it is combinational in `send_rdy` when in FULL.
- In COLLECT, `send_rdy` is ignored. In FULL without overlap, `recv_val` is ignored and no word is consumed.
- Reset deassertion is synchronised externally; the block needs no recovery cycles beyond the first edge.

## Configuration
- Macro: `DESERIALIZER_OVERLAP_EN`.
- **Defined:**
  - In FULL, `recv_rdy = send_rdy`.
  - If `send_rdy && recv_val` at the same edge: the frame transfers, `recv_msg` is written to `buf[0]`, `cnt <= 1`, and the state becomes COLLECT.
  - The outgoing frame is sampled from the old `buf[0]` at that edge.
  - This removes the one-cycle bubble between frames.
- **Undefined:**
  - `recv_rdy=0` throughout FULL.
  - After the frame handshake, one COLLECT cycle with `cnt=0` always precedes the next word.

## Test plan
- **Reset values:** hold `reset=0` with random inputs -> `send_val=0`, `recv_rdy=0`, all `send_msg[i]=0`. Release -> `recv_rdy=1` on the next cycle.
- **Single frame:** `N_SAMPLES=8`, `send_rdy=1`, feed 0x10..0x17 back-to-back.
  - Required: `send_val=1` exactly one cycle after 0x17 is accepted.
  - Required: `send_msg[0]=0x10` through `send_msg[7]=0x17`.
  - Required: `send_val` drops after one cycle.
- **Backpressure:** complete a frame with `send_rdy=0` for 5 cycles while `recv_val=1` and `recv_msg=0xFF`.
  - Required: `send_msg` is unchanged and `recv_rdy` stays 0 throughout (macro undefined).
  - Required: after `send_rdy` goes high, the frame transfers once and `recv_rdy=1` on the next cycle.
- **Gapped input:** deassert `recv_val` randomly for 0-3 cycles between the words 1..8 -> the frame equals 1..8 in order and `cnt` does not advance during gaps.
- **Reset mid-frame:** accept 0xA0..0xA2, pulse `reset=0` asynchronously between edges, then feed 0xB0..0xB7 -> the output frame is 0xB0..0xB7 with no 0xA* word.
- **Overlap (`DESERIALIZER_OVERLAP_EN` defined):** stream 16 words continuously with `send_rdy=1`.
  - Required: two frames spaced exactly 8 cycles apart.
  - Required: the second frame's word 0 is accepted in the same cycle the first frame transfers.

Source files
------------

// File: rtl/deserializer_vrtl_if.sv
// Handshake bundle for deserializer_vrtl: serial val/rdy input on the recv side and
// a parallel-frame val/rdy output on the send side. The slave modport is the block's view.
interface deserializer_vrtl_if #(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned N_SAMPLES = 8
) ();

    logic [BIT_WIDTH-1:0] recv_msg;
    logic                 recv_val;
    logic                 recv_rdy;

    logic [BIT_WIDTH-1:0] send_msg [N_SAMPLES-1:0];
    logic                 send_val;
    logic                 send_rdy;

    // Upstream word source / downstream frame sink
    modport master (
        output recv_msg,
        output recv_val,
        input  recv_rdy,
        input  send_msg,
        input  send_val,
        output send_rdy
    );

    // The deserializer itself
    modport slave (
        input  recv_msg,
        input  recv_val,
        output recv_rdy,
        output send_msg,
        output send_val,
        input  send_rdy
    );

endinterface

// File: rtl/deserializer_vrtl.sv
// deserializer_vrtl: gathers N_SAMPLES serial words (first word into send_msg[0]) and
// offers them as one parallel frame. Optional macro DESERIALIZER_OVERLAP_EN lets the
// first word of the next frame be accepted on the same edge the current frame leaves,
// removing the one-cycle bubble between frames.
module deserializer_vrtl #(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned N_SAMPLES = 8
) (
    input logic                clk,
    input logic                reset,
    deserializer_vrtl_if.slave bus
);

    localparam int unsigned CntW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(N_SAMPLES - 1);

    typedef enum logic {
        StCollect,
        StFull
    } state_e;

    state_e               state_q;
    logic [CntW-1:0]      cnt_q;
    logic [BIT_WIDTH-1:0] buf_q [N_SAMPLES];

    // FSM, write counter and word storage; buf_q is frozen while a frame waits in FULL
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StCollect;
            cnt_q   <= '0;
            for (int i = 0; i < int'(N_SAMPLES); i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            case (state_q)
                StCollect: begin
                    if (bus.recv_val) begin
                        buf_q[cnt_q] <= bus.recv_msg;
                        if (cnt_q == CntLast) begin
                            cnt_q   <= '0;
                            state_q <= StFull;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StFull: begin
                    if (bus.send_rdy) begin
`ifdef DESERIALIZER_OVERLAP_EN
                        // Outgoing frame was sampled from the old buf_q[0] at this edge
                        if (bus.recv_val) begin
                            buf_q[0] <= bus.recv_msg;
                            cnt_q    <= CntW'(1);
                        end
`endif
                        state_q <= StCollect;
                    end
                end
                default: begin
                    state_q <= StCollect;
                end
            endcase
        end
    end

    // Handshake outputs; recv_rdy is held low for as long as reset is asserted
    always_comb begin
        bus.send_val = (state_q == StFull);
        bus.recv_rdy = 1'b0;
        if (reset) begin
            if (state_q == StCollect) begin
                bus.recv_rdy = 1'b1;
            end
`ifdef DESERIALIZER_OVERLAP_EN
            else begin
                bus.recv_rdy = bus.send_rdy;
            end
`endif
        end
    end

    // Frame is a direct view of the word registers
    always_comb begin
        for (int i = 0; i < int'(N_SAMPLES); i++) begin
            bus.send_msg[i] = buf_q[i];
        end
    end

    // Counter never leaves 0..N_SAMPLES-1 and sits at 0 whenever a frame is held
    a_cnt_range : assert property (@(posedge clk) disable iff (!reset) cnt_q <= CntLast);
    a_full_cnt0 : assert property (@(posedge clk) disable iff (!reset)
                                   (state_q == StFull) |-> (cnt_q == '0));

endmodule

// File: tb/tb_deserializer_vrtl.sv
// Scoreboard bench for deserializer_vrtl: stimulus pushes expected frames, a monitor pops
// and compares on every frame transfer.
module tb_deserializer_vrtl;

    localparam int unsigned BW = 32;
    localparam int unsigned NS = 8;

    typedef logic [NS-1:0][BW-1:0] frame_t;

    logic clk;
    logic reset;

    deserializer_vrtl_if #(.BIT_WIDTH(BW), .N_SAMPLES(NS)) bus ();

    deserializer_vrtl #(
        .BIT_WIDTH(BW),
        .N_SAMPLES(NS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int     n_cmp  = 0;
    int     n_fail = 0;
    int     cyc    = 0;
    frame_t exp_q[$];
    int     xfer_cyc[$];
    int     last_acc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] msg_or();
        logic [31:0] r = '0;
        for (int i = 0; i < int'(NS); i++) r |= bus.send_msg[i];
        return r;
    endfunction

    function automatic frame_t make_frame(input logic [31:0] base);
        frame_t f;
        for (int i = 0; i < int'(NS); i++) f[i] = base + 32'(i);
        return f;
    endfunction

    // Monitor: every frame handshake pops one expected frame
    always @(negedge clk) begin
        if (reset && bus.send_val && bus.send_rdy) begin
            xfer_cyc.push_back(cyc + 1);
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 32'd1, 32'd0);
            end else begin
                frame_t e;
                e = exp_q.pop_front();
                for (int i = 0; i < int'(NS); i++) begin
                    check($sformatf("frame_word[%0d]", i), bus.send_msg[i], e[i]);
                end
            end
        end
    end

    // Present one word and hold it until accepted (bounded)
    task automatic send_word(input logic [31:0] w);
        int t = 0;
        bus.recv_msg = w;
        bus.recv_val = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.recv_rdy && t < 50);
        if (!bus.recv_rdy) check("recv_rdy_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        last_acc     = cyc;
        bus.recv_val = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] base);
        for (int i = 0; i < int'(NS); i++) send_word(base + 32'(i));
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        reset        = 1'b1;
        bus.recv_msg = '0;
        bus.recv_val = 1'b0;
        bus.send_rdy = 1'b0;
        #1 reset = 1'b0;

        // Reset values under random inputs
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            bus.recv_msg = $urandom;
            bus.recv_val = 1'($urandom_range(0, 1));
            bus.send_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rst_send_val", 32'(bus.send_val), 32'd0);
            check("rst_recv_rdy", 32'(bus.recv_rdy), 32'd0);
            check("rst_send_msg", msg_or(), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.recv_val = 1'b0;
        bus.send_rdy = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        check("post_rst_recv_rdy", 32'(bus.recv_rdy), 32'd1);
        @(posedge clk);
        #1;

        // Single frame, one cycle latency, one-cycle send_val pulse
        bus.send_rdy = 1'b1;
        exp_q.push_back(make_frame(32'h10));
        send_frame(32'h10);
        @(negedge clk);
        check("latency_send_val", 32'(bus.send_val), 32'd1);
        @(negedge clk);
        check("send_val_drop", 32'(bus.send_val), 32'd0);
        @(posedge clk);
        #1;

        // Backpressure: frame held, no words consumed
        bus.send_rdy = 1'b0;
        exp_q.push_back(make_frame(32'h20));
        send_frame(32'h20);
        bus.recv_msg = 32'hFF;
        bus.recv_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_send_val", 32'(bus.send_val), 32'd1);
            check("bp_recv_rdy", 32'(bus.recv_rdy), 32'd0);
            check("bp_msg0", bus.send_msg[0], 32'h20);
            check("bp_msg7", bus.send_msg[7], 32'h27);
        end
        @(posedge clk);
        #1;
        bus.recv_val = 1'b0;
        bus.send_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_after_recv_rdy", 32'(bus.recv_rdy), 32'd1);
        check("bp_after_send_val", 32'(bus.send_val), 32'd0);
        check("bp_single_xfer", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;

        // Gapped input: counter holds through idle cycles
        exp_q.push_back(make_frame(32'h1));
        for (int i = 0; i < int'(NS); i++) begin
            send_word(32'(i + 1));
            if (i < int'(NS) - 1) begin
                gap = (i == 2) ? 2 : int'($urandom_range(0, 3));
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    check("gap_cnt", 32'(dut.cnt_q), 32'(i + 1));
                    @(posedge clk);
                    #1;
                end
            end
        end
        wait_drain();

        // Reset mid-frame: partial 0xA* words are discarded
        send_word(32'hA0);
        send_word(32'hA1);
        send_word(32'hA2);
        #2 reset = 1'b0;
        #1;
        check("midrst_recv_rdy", 32'(bus.recv_rdy), 32'd0);
        check("midrst_msg", msg_or(), 32'd0);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(make_frame(32'hB0));
        send_frame(32'hB0);
        wait_drain();

`ifdef DESERIALIZER_OVERLAP_EN
        // Overlap: 16 back-to-back words, frames 8 cycles apart
        begin
            int acc8;
            xfer_cyc.delete();
            exp_q.push_back(make_frame(32'hC0));
            exp_q.push_back(make_frame(32'hD0));
            send_frame(32'hC0);
            send_word(32'hD0);
            acc8 = last_acc;
            for (int i = 1; i < int'(NS); i++) send_word(32'hD0 + 32'(i));
            wait_drain();
            if (xfer_cyc.size() < 2) begin
                check("ov_frame_count", 32'(xfer_cyc.size()), 32'd2);
            end else begin
                check("ov_spacing", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd8);
                check("ov_same_edge", 32'(acc8), 32'(xfer_cyc[0]));
            end
        end
`endif

        repeat (3) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
